// File: rtl/fpu_issue_seq_32.sv
// Issue sequencer in front of fpu_top_32: credit-checked valid/ready requests, in-order tagged
// responses through a small FIFO, local qNaN service for DIV, and sticky exception flags.
module fpu_issue_seq_32 #(
    parameter int BIT_WIDTH = 32,
    parameter int TAG_W     = 4,
    parameter int FPU_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [1:0]           i_req_op,
    input  logic [2:0]           i_req_mode,
    input  logic [BIT_WIDTH-1:0] i_req_a,
    input  logic [BIT_WIDTH-1:0] i_req_b,
    input  logic [TAG_W-1:0]     i_req_tag,
    output logic                 o_fpu_valid,
    output logic [2:0]           o_fpu_mode,
    output logic [1:0]           o_fpu_operation,
    output logic [BIT_WIDTH-1:0] o_fpu_inputA,
    output logic [BIT_WIDTH-1:0] o_fpu_inputB,
    input  logic [BIT_WIDTH-1:0] i_fpu_output,
    input  logic [4:0]           i_fpu_exeption,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [BIT_WIDTH-1:0] o_rsp_data,
    output logic [4:0]           o_rsp_exc,
    output logic [TAG_W-1:0]     o_rsp_tag,
    input  logic                 i_sticky_clr,
    output logic [4:0]           o_sticky_exc
);

    localparam int STAGES = 1 + FPU_LAT;
    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = $clog2(RSP_DEPTH + STAGES + 1) + 1;
    localparam logic [1:0]           OP_DIV   = 2'b11;
    localparam logic [BIT_WIDTH-1:0] QNAN     = BIT_WIDTH'(32'h7FC0_0000);
    localparam logic [4:0]           EXC_DIV  = 5'b00010;

    typedef struct packed {
        logic [BIT_WIDTH-1:0] data;
        logic [4:0]           exc;
        logic [TAG_W-1:0]     tag;
    } rsp_t;

    logic [STAGES:1]            vld_pipe;
    logic [STAGES:1]            loc_pipe;
    logic [STAGES:1][TAG_W-1:0] tag_pipe;

    rsp_t             fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic [CNT_W-1:0] inflight;
    logic [4:0]       sticky;

    logic accept, is_div, push, pop;
    rsp_t push_ent, head;

    // Credits come from registered state only, so a pop frees its slot one cycle later.
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= STAGES; i++)
            inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    assign o_req_ready = (inflight + CNT_W'(fifo_count)) < CNT_W'(RSP_DEPTH);
    assign accept      = i_req_valid & o_req_ready;
    assign is_div      = (i_req_op == OP_DIV);

    assign push = vld_pipe[STAGES];
    always_comb begin
        push_ent.tag = tag_pipe[STAGES];
        if (loc_pipe[STAGES]) begin
            push_ent.data = QNAN;
            push_ent.exc  = EXC_DIV;
        end else begin
            push_ent.data = i_fpu_output;
            push_ent.exc  = i_fpu_exeption;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            loc_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            loc_pipe <= {loc_pipe[STAGES-1:1], is_div};
            tag_pipe <= {tag_pipe[STAGES-1:1], i_req_tag};
        end
    end

    // DIV never reaches the FPU; its issue registers keep the previous operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_fpu_valid     <= 1'b0;
            o_fpu_mode      <= '0;
            o_fpu_operation <= '0;
            o_fpu_inputA    <= '0;
            o_fpu_inputB    <= '0;
        end else begin
            o_fpu_valid <= accept & ~is_div;
            if (accept & ~is_div) begin
                o_fpu_mode      <= i_req_mode;
                o_fpu_operation <= i_req_op;
                o_fpu_inputA    <= i_req_a;
                o_fpu_inputB    <= i_req_b;
            end
        end
    end

    assign o_rsp_valid = (fifo_count != '0);
    assign pop         = o_rsp_valid & i_rsp_ready;
    assign head        = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    assign o_rsp_data = o_rsp_valid ? head.data : '0;
    assign o_rsp_exc  = o_rsp_valid ? head.exc  : '0;
    assign o_rsp_tag  = o_rsp_valid ? head.tag  : '0;

    // A clear coinciding with a push keeps the pushed bits.
    always_ff @(posedge clk) begin
        if (rst) sticky <= '0;
        else     sticky <= (i_sticky_clr ? 5'b0 : sticky) | (push ? push_ent.exc : 5'b0);
    end
    assign o_sticky_exc = sticky;

    a_no_full_push: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count == (PTR_W+1)'(RSP_DEPTH)));

endmodule

// File: tb/tb_fpu_issue_seq_32.sv
// Bench for fpu_issue_seq_32: a stub FPU with one cycle of latency, a queue-based response model,
// directed scenarios and a randomized traffic run.
module tb_fpu_issue_seq_32;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, rsp_ready = 0, sticky_clr = 0;
    logic [1:0]  op = 0;
    logic [2:0]  mode = 0;
    logic [31:0] a = 0, b = 0;
    logic [3:0]  tag = 0;
    logic        o_req_ready, o_fpu_valid, o_rsp_valid;
    logic [2:0]  o_fpu_mode;
    logic [1:0]  o_fpu_operation;
    logic [31:0] o_fpu_inputA, o_fpu_inputB, fpu_out, o_rsp_data;
    logic [4:0]  fpu_exc, o_rsp_exc, o_sticky_exc;
    logic [3:0]  o_rsp_tag;

    always #5 clk = ~clk;

    fpu_issue_seq_32 #(.BIT_WIDTH(32), .TAG_W(4), .FPU_LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_op(op), .i_req_mode(mode),
        .i_req_a(a), .i_req_b(b), .i_req_tag(tag),
        .o_fpu_valid(o_fpu_valid), .o_fpu_mode(o_fpu_mode), .o_fpu_operation(o_fpu_operation),
        .o_fpu_inputA(o_fpu_inputA), .o_fpu_inputB(o_fpu_inputB),
        .i_fpu_output(fpu_out), .i_fpu_exeption(fpu_exc),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(o_rsp_data),
        .o_rsp_exc(o_rsp_exc), .o_rsp_tag(o_rsp_tag),
        .i_sticky_clr(sticky_clr), .o_sticky_exc(o_sticky_exc)
    );

    // Stand-in FPU: exact results for the known float cases, a mixing function otherwise.
    function automatic logic [36:0] fpu_fn(input logic [1:0] fop, input logic [2:0] md,
                                           input logic [31:0] x, input logic [31:0] y);
        if (fop == 2'd0 && x == 32'h3F800000 && y == 32'h40000000) return {5'b0, 32'h40400000};
        if (fop == 2'd2 && x == 32'h40000000 && y == 32'h40400000) return {5'b0, 32'h40C00000};
        if (fop == 2'd1 && x == 32'h40400000 && y == 32'h3F800000) return {5'b0, 32'h40000000};
        if (fop == 2'd2 && x == 32'h7F7FFFFF && y == 32'h40000000) return {5'b10001, 32'h7F800000};
        return {x[4:0] ^ y[4:0], x ^ {y[15:0], y[31:16]} ^ {27'b0, md, fop}};
    endfunction

    // Garbage whenever nothing was issued, so a mistimed capture shows up.
    always @(posedge clk) begin
        if (o_fpu_valid) {fpu_exc, fpu_out} <= fpu_fn(o_fpu_operation, o_fpu_mode, o_fpu_inputA, o_fpu_inputB);
        else begin
            fpu_out <= $urandom;
            fpu_exc <= 5'($urandom);
        end
    end

    typedef struct { logic [31:0] d; logic [4:0] e; logic [3:0] t; int avail; } exp_t;
    exp_t       exp_q[$];
    int         cyc = 0;
    logic [4:0] sticky_m = 0;
    logic       exp_fpu_v = 0;
    int         n_checks = 0, n_pass = 0;

    function automatic logic exp_rsp_valid();
        return exp_q.size() > 0 && exp_q[0].avail <= cyc;
    endfunction

    // Advance one clock and update the model: every accepted, unpopped request holds one credit,
    // and each response becomes visible 1+LAT edges after its accept.
    task automatic step();
        logic acc, pp;
        logic [4:0] newx;
        logic [36:0] f;
        exp_t r;
        acc = req_valid && (exp_q.size() < DEPTH);
        pp  = rsp_ready && exp_rsp_valid();
        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            sticky_m  = 0;
            exp_fpu_v = 0;
        end else begin
            newx = 0;
            foreach (exp_q[i]) if (exp_q[i].avail == cyc) newx |= exp_q[i].e;
            sticky_m = (sticky_clr ? 5'b0 : sticky_m) | newx;
            if (pp) void'(exp_q.pop_front());
            if (acc) begin
                f = fpu_fn(op, mode, a, b);
                r.d = (op == 2'd3) ? 32'h7FC00000 : f[31:0];
                r.e = (op == 2'd3) ? 5'b00010 : f[36:32];
                r.t = tag;
                r.avail = cyc + 1 + LAT;
                exp_q.push_back(r);
            end
            exp_fpu_v = acc && (op != 2'd3);
        end
        #1;
    endtask

    task automatic set_req(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
        req_valid = 1; op = o; mode = 0; a = x; b = y; tag = t;
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        rst = 0;
        n_checks++; if (o_req_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", o_req_ready); else n_pass++;
        n_checks++; if (o_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b exp 0", o_rsp_valid); else n_pass++;
        n_checks++; if (o_fpu_valid !== 1'b0) $display("FAIL reset_fpu_valid got %0b exp 0", o_fpu_valid); else n_pass++;
        n_checks++; if ({o_sticky_exc, o_rsp_data, o_rsp_exc, o_rsp_tag} !== 46'b0) $display("FAIL reset_outputs got %h exp 0", {o_sticky_exc, o_rsp_data, o_rsp_exc, o_rsp_tag}); else n_pass++;
    endtask

    task automatic test_add_latency();
        rsp_ready = 1;
        set_req(2'd0, 32'h3F800000, 32'h40000000, 4'd5);
        step(); req_valid = 0;
        n_checks++; if ({o_fpu_valid, o_fpu_operation, o_fpu_mode} !== 6'b1_00_000) $display("FAIL add_issue got %b exp 100000", {o_fpu_valid, o_fpu_operation, o_fpu_mode}); else n_pass++;
        n_checks++; if ({o_fpu_inputA, o_fpu_inputB} !== {32'h3F800000, 32'h40000000}) $display("FAIL add_operands got %h", {o_fpu_inputA, o_fpu_inputB}); else n_pass++;
        step();
        n_checks++; if ({o_fpu_valid, o_rsp_valid} !== 2'b00) $display("FAIL add_one_cycle got %b exp 00", {o_fpu_valid, o_rsp_valid}); else n_pass++;
        step();
        n_checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_exc} !== {1'b1, 32'h40400000, 4'd5, 5'b0}) $display("FAIL add_rsp got %b %h %0d %b exp 1 40400000 5 00000", o_rsp_valid, o_rsp_data, o_rsp_tag, o_rsp_exc); else n_pass++;
        step();
        n_checks++; if (o_rsp_valid !== 1'b0) $display("FAIL add_popped got %0b exp 0", o_rsp_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1;
        set_req(2'd2, 32'h40000000, 32'h40400000, 4'd1);
        step();
        n_checks++; if ({o_fpu_valid, o_fpu_operation} !== 3'b1_10) $display("FAIL b2b_mul_issue got %b exp 110", {o_fpu_valid, o_fpu_operation}); else n_pass++;
        set_req(2'd1, 32'h40400000, 32'h3F800000, 4'd2);
        step(); req_valid = 0;
        n_checks++; if ({o_fpu_valid, o_fpu_operation, o_fpu_inputA} !== {3'b1_01, 32'h40400000}) $display("FAIL b2b_sub_issue got %b %h", {o_fpu_valid, o_fpu_operation}, o_fpu_inputA); else n_pass++;
        step();
        n_checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_tag} !== {1'b1, 32'h40C00000, 4'd1}) $display("FAIL b2b_first got %b %h %0d exp 1 40c00000 1", o_rsp_valid, o_rsp_data, o_rsp_tag); else n_pass++;
        step();
        n_checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_tag} !== {1'b1, 32'h40000000, 4'd2}) $display("FAIL b2b_second got %b %h %0d exp 1 40000000 2", o_rsp_valid, o_rsp_data, o_rsp_tag); else n_pass++;
        step();
    endtask

    task automatic test_div();
        rsp_ready = 1;
        set_req(2'd0, 32'h3F800000, 32'h40000000, 4'd1); step();
        set_req(2'd3, 32'h12345678, 32'h9ABCDEF0, 4'd3); step();
        n_checks++; if ({o_fpu_valid, o_fpu_operation, o_fpu_inputA} !== {3'b0_00, 32'h3F800000}) $display("FAIL div_no_issue got %b %h exp 000 3f800000", {o_fpu_valid, o_fpu_operation}, o_fpu_inputA); else n_pass++;
        set_req(2'd0, 32'h3F800000, 32'h40000000, 4'd7); step(); req_valid = 0;
        n_checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_tag} !== {1'b1, 32'h40400000, 4'd1}) $display("FAIL div_first_add got %b %h %0d", o_rsp_valid, o_rsp_data, o_rsp_tag); else n_pass++;
        step();
        n_checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_exc, o_rsp_tag} !== {1'b1, 32'h7FC00000, 5'b00010, 4'd3}) $display("FAIL div_rsp got %b %h %b %0d exp 1 7fc00000 00010 3", o_rsp_valid, o_rsp_data, o_rsp_exc, o_rsp_tag); else n_pass++;
        step();
        n_checks++; if ({o_rsp_valid, o_rsp_data, o_rsp_tag} !== {1'b1, 32'h40400000, 4'd7}) $display("FAIL div_last_add got %b %h %0d", o_rsp_valid, o_rsp_data, o_rsp_tag); else n_pass++;
        step();
    endtask

    task automatic test_credit();
        int acc;
        logic [36:0] f;
        acc = 0;
        rsp_ready = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(2'd0, 32'(i), 32'h10, 4'(i));
            if (o_req_ready) acc++;
            step();
        end
        req_valid = 0;
        n_checks++; if (acc !== 4) $display("FAIL credit_accepts got %0d exp 4", acc); else n_pass++;
        n_checks++; if ({o_req_ready, o_rsp_valid, o_rsp_tag} !== {2'b01, 4'd0}) $display("FAIL credit_full got rdy %0b vld %0b tag %0d exp 0 1 0", o_req_ready, o_rsp_valid, o_rsp_tag); else n_pass++;
        rsp_ready = 1;
        for (int i = 1; i < 4; i++) begin
            step();
            f = fpu_fn(2'd0, 3'd0, 32'(i), 32'h10);
            n_checks++; if ({o_req_ready, o_rsp_valid, o_rsp_tag, o_rsp_data} !== {2'b11, 4'(i), f[31:0]}) $display("FAIL credit_drain%0d got rdy %0b vld %0b tag %0d data %h exp 1 1 %0d %h", i, o_req_ready, o_rsp_valid, o_rsp_tag, o_rsp_data, i, f[31:0]); else n_pass++;
        end
        step();
        n_checks++; if (o_rsp_valid !== 1'b0) $display("FAIL credit_empty got %0b exp 0", o_rsp_valid); else n_pass++;
    endtask

    task automatic test_sticky();
        sticky_clr = 1; step(); sticky_clr = 0;
        n_checks++; if (o_sticky_exc !== 5'b0) $display("FAIL sticky_clr got %b exp 00000", o_sticky_exc); else n_pass++;
        rsp_ready = 1;
        set_req(2'd2, 32'h7F7FFFFF, 32'h40000000, 4'd9); step(); req_valid = 0;
        step(); step();
        n_checks++; if ({o_rsp_exc, o_sticky_exc} !== {5'b10001, 5'b10001}) $display("FAIL sticky_ovf got exc %b sticky %b exp 10001 10001", o_rsp_exc, o_sticky_exc); else n_pass++;
        set_req(2'd0, 32'h1, 32'h0, 4'd2); step(); req_valid = 0;
        step();
        sticky_clr = 1; step(); sticky_clr = 0;
        n_checks++; if ({o_rsp_exc, o_sticky_exc} !== {5'b00001, 5'b00001}) $display("FAIL sticky_clr_push got exc %b sticky %b exp 00001 00001", o_rsp_exc, o_sticky_exc); else n_pass++;
        step();
    endtask

    task automatic test_reset_midop();
        int late;
        late = 0;
        rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(2'd2, 32'h3, 32'h0, 4'(i));
            step();
        end
        n_checks++; if ({o_req_ready, o_rsp_valid, o_sticky_exc} !== {2'b01, 5'b00011}) $display("FAIL midop_loaded got rdy %0b vld %0b sticky %b exp 0 1 00011", o_req_ready, o_rsp_valid, o_sticky_exc); else n_pass++;
        rst = 1; step(); rst = 0; req_valid = 0;
        n_checks++; if ({o_rsp_valid, o_sticky_exc, o_req_ready, o_fpu_valid} !== {1'b0, 5'b0, 2'b10}) $display("FAIL midop_reset got vld %0b sticky %b rdy %0b fv %0b exp 0 00000 1 0", o_rsp_valid, o_sticky_exc, o_req_ready, o_fpu_valid); else n_pass++;
        repeat (5) begin
            step();
            if (o_rsp_valid !== 1'b0) late++;
        end
        n_checks++; if (late !== 0) $display("FAIL midop_late_rsp got %0d late cycles exp 0", late); else n_pass++;
    endtask

    task automatic test_random();
        int fails;
        fails = 0;
        repeat (500) begin
            req_valid  = $urandom_range(0, 1);
            op         = 2'($urandom_range(0, 3));
            mode       = 3'($urandom_range(0, 4));
            a          = $urandom;
            b          = $urandom;
            tag        = 4'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 15) == 0);
            n_checks++; if (o_req_ready !== (exp_q.size() < DEPTH)) begin fails++; if (fails < 10) $display("FAIL rnd_ready cyc %0d got %0b exp %0b", cyc, o_req_ready, exp_q.size() < DEPTH); end else n_pass++;
            step();
            n_checks++; if (o_rsp_valid !== exp_rsp_valid()) begin fails++; if (fails < 10) $display("FAIL rnd_rsp_valid cyc %0d got %0b exp %0b", cyc, o_rsp_valid, exp_rsp_valid()); end else n_pass++;
            if (exp_rsp_valid()) begin
                n_checks++; if ({o_rsp_data, o_rsp_exc, o_rsp_tag} !== {exp_q[0].d, exp_q[0].e, exp_q[0].t}) begin fails++; if (fails < 10) $display("FAIL rnd_rsp cyc %0d got %h %b %0d exp %h %b %0d", cyc, o_rsp_data, o_rsp_exc, o_rsp_tag, exp_q[0].d, exp_q[0].e, exp_q[0].t); end else n_pass++;
            end
            n_checks++; if (o_sticky_exc !== sticky_m) begin fails++; if (fails < 10) $display("FAIL rnd_sticky cyc %0d got %b exp %b", cyc, o_sticky_exc, sticky_m); end else n_pass++;
            n_checks++; if (o_fpu_valid !== exp_fpu_v) begin fails++; if (fails < 10) $display("FAIL rnd_fpu_valid cyc %0d got %0b exp %0b", cyc, o_fpu_valid, exp_fpu_v); end else n_pass++;
        end
        req_valid = 0; sticky_clr = 0; rsp_ready = 1;
        repeat (8) step();
        n_checks++; if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) $display("FAIL rnd_drain got vld %0b rdy %0b exp 0 1", o_rsp_valid, o_req_ready); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_latency();
        test_back_to_back();
        test_div();
        test_credit();
        test_sticky();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
